uart_reg_responder: RTL and testbench

- UART-side register-access responder: parses the command byte stream from the 8N1 receiver and answers through the 8N1 transmitter.
- Drives the transmitter's tx_data/tx_start/tx_busy handshake and consumes the receiver's rx_data/rx_ready outputs.
- Holds NREG 8-bit control registers that a host PC reads and writes over the serial line.
- Sits beside uart_8n1 in the top level.

---
 rtl/uart_reg_responder.sv | 161 ++++++++++++++++
 tb/tb_uart_reg_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder.sv
// Serial register-access responder: parses W/R command frames from the
// UART receiver and answers through the transmitter. Optional macro: UART_TIMEOUT_EN.
module uart_reg_responder #(
  parameter int NREG           = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [8*NREG-1:0] regs,
  output logic              wr_strobe,
  output logic [7:0]        wr_addr,
  output logic              overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  localparam logic [7:0] C_W = 8'h57;
  localparam logic [7:0] C_R = 8'h52;
  localparam logic [7:0] C_K = 8'h4B;
  localparam logic [7:0] C_Q = 8'h3F;

  localparam logic [8:0] NREG9 = 9'(NREG);

  logic [2:0] r_state;
  logic       r_rx_q;
  logic       r_is_wr;
  logic [7:0] r_addr;
  logic [7:0] r_tx_data;
  logic       r_tx_start;
  logic       r_wr_strobe;
  logic [7:0] r_wr_addr;
  logic       r_overrun;
  logic [7:0] r_mem [NREG];

  logic       w_evt;
  logic       w_rx_ok;
  logic       w_addr_ok;
  logic       w_to_hit;
  logic [7:0] w_rd;

  assign w_evt     = rx_ready & ~r_rx_q;
  assign w_rx_ok   = {1'b0, rx_data} < NREG9;
  assign w_addr_ok = {1'b0, r_addr} < NREG9;

  always_comb begin
    w_rd = 8'h00;
    for (int i = 0; i < NREG; i++)
      if (rx_data == 8'(i)) w_rd = r_mem[i];
  end

`ifdef UART_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  assign w_to_hit = (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Runs only while a frame is partially received.
  always_ff @(posedge hclk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (w_evt || !(r_state == S_ADDR || r_state == S_DATA)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end
`else
  logic w_unused_to;

  assign w_unused_to = (TIMEOUT_CYCLES != 0);
  assign w_to_hit    = 1'b0;
`endif

  always_ff @(posedge hclk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rx_q      <= 1'b0;
      r_is_wr     <= 1'b0;
      r_addr      <= 8'h00;
      r_tx_data   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 8'h00;
      r_overrun   <= 1'b0;
      for (int i = 0; i < NREG; i++) r_mem[i] <= 8'h00;
    end else begin
      r_rx_q      <= rx_ready;
      r_wr_strobe <= 1'b0;
      case (r_state)
        S_IDLE: if (w_evt) begin
          if (rx_data == C_W || rx_data == C_R) begin
            r_is_wr <= (rx_data == C_W);
            r_state <= S_ADDR;
          end else begin
            r_tx_data  <= C_Q;
            r_tx_start <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_ADDR: if (w_evt) begin
          r_addr <= rx_data;
          if (r_is_wr) begin
            r_state <= S_DATA;
          end else begin
            r_tx_data  <= w_rx_ok ? w_rd : C_Q;
            r_tx_start <= 1'b1;
            r_state    <= S_REQ;
          end
        end else if (w_to_hit) begin
          r_state <= S_IDLE;
        end
        S_DATA: if (w_evt) begin
          if (w_addr_ok) begin
            for (int i = 0; i < NREG; i++)
              if (r_addr == 8'(i)) r_mem[i] <= rx_data;
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_addr;
            r_tx_data   <= C_K;
          end else begin
            r_tx_data <= C_Q;
          end
          r_tx_start <= 1'b1;
          r_state    <= S_REQ;
        end else if (w_to_hit) begin
          r_state <= S_IDLE;
        end
        S_REQ: begin
          if (w_evt) r_overrun <= 1'b1;
          if (tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_evt) r_overrun <= 1'b1;
          if (!tx_busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs[8*g +: 8] = r_mem[g];
  end

  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder with a transmitter model
// and a queue of expected response bytes.
module tb_uart_reg_responder;

  logic        hclk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [31:0] regs;
  logic        wr_strobe;
  logic [7:0]  wr_addr;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int st_cnt = 0;
  logic [7:0] last_wa = 8'h00;
  logic model_en = 1'b1;
  logic model_busy = 1'b0;
  logic [7:0] exp_q [$];

  always #5 hclk = ~hclk;

  uart_reg_responder #(.NREG(4), .TIMEOUT_CYCLES(100)) dut (
    .hclk(hclk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge hclk);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (2) @(negedge hclk);
    rx_ready = 1'b0;
    repeat (2) @(negedge hclk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || model_busy || tx_start || tx_busy)
           && n < 400) begin
      @(negedge hclk);
      n++;
    end
    chk("idle_bound", 32'(n < 400), 32'd1);
  endtask

  always @(negedge hclk) begin
    if (wr_strobe) begin
      st_cnt++;
      last_wa = wr_addr;
    end
  end

  // Transmitter: busy 3 cycles after start, stays busy 50 cycles.
  always begin
    logic [7:0] got;
    logic [7:0] e;
    logic stable;
    @(negedge hclk);
    if (model_en && rst && tx_start && !tx_busy) begin
      model_busy = 1'b1;
      hs_cnt++;
      repeat (3) begin
        @(negedge hclk);
        chk("start_held", 32'(tx_start), 32'd1);
      end
      tx_busy = 1'b1;
      got = tx_data;
      if (exp_q.size() == 0) begin
        chk("extra_resp", {24'h0, got}, 32'h100);
      end else begin
        e = exp_q.pop_front();
        chk("resp", {24'h0, got}, {24'h0, e});
      end
      @(negedge hclk);
      chk("start_drop", 32'(tx_start), 32'd0);
      stable = 1'b1;
      repeat (49) begin
        @(negedge hclk);
        if (tx_data !== got) stable = 1'b0;
      end
      chk("data_stable", 32'(stable), 32'd1);
      tx_busy = 1'b0;
      @(negedge hclk);
      model_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int sc0;
    int n;
    logic [31:0] snap;

    repeat (3) @(negedge hclk);
    chk("rst_regs", regs, 32'h0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_txd", {24'h0, tx_data}, 32'h0);
    chk("rst_wrs", 32'(wr_strobe), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge hclk);

    hs0 = hs_cnt;
    exp_q.push_back(8'h00);
    send_byte(8'h52);
    send_byte(8'h02);
    wait_idle();
    chk("read0_hs", 32'(hs_cnt - hs0), 32'd1);

    sc0 = st_cnt;
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_byte(8'h01);
    send_byte(8'hA5);
    wait_idle();
    chk("wr_strobe_cnt", 32'(st_cnt - sc0), 32'd1);
    chk("wr_addr", {24'h0, last_wa}, 32'h1);
    chk("wr_reg1", {24'h0, regs[15:8]}, 32'hA5);
    exp_q.push_back(8'hA5);
    send_byte(8'h52);
    send_byte(8'h01);
    wait_idle();

    snap = regs;
    sc0 = st_cnt;
    exp_q.push_back(8'h3F);
    send_byte(8'h57);
    send_byte(8'h04);
    send_byte(8'h33);
    wait_idle();
    chk("oor_regs", regs, snap);
    chk("oor_strobe", 32'(st_cnt - sc0), 32'd0);
    exp_q.push_back(8'h3F);
    send_byte(8'h10);
    wait_idle();
    exp_q.push_back(8'h00);
    send_byte(8'h52);
    send_byte(8'h03);
    wait_idle();

    hs0 = hs_cnt;
    exp_q.push_back(8'h00);
    send_byte(8'h52);
    send_byte(8'h00);
    n = 0;
    while (!tx_busy && n < 50) begin
      @(negedge hclk);
      n++;
    end
    chk("busy_seen", 32'(tx_busy), 32'd1);
    send_byte(8'h55);
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_idle();
    chk("ovr_hs", 32'(hs_cnt - hs0), 32'd1);
    exp_q.push_back(8'hA5);
    send_byte(8'h52);
    send_byte(8'h01);
    wait_idle();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    snap = regs;
    hs0 = hs_cnt;
    send_byte(8'h57);
    repeat (150) @(negedge hclk);
    chk("to_no_resp", 32'(hs_cnt - hs0), 32'd0);
`ifdef UART_TIMEOUT_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h3F);
`endif
    send_byte(8'h52);
    send_byte(8'h00);
    wait_idle();
    chk("to_regs", regs, snap);

    model_en = 1'b0;
    send_byte(8'h57);
    send_byte(8'h02);
    @(negedge hclk);
    rst = 1'b0;
    #1;
    chk("rst1_regs", regs, 32'h0);
    chk("rst1_ovr", 32'(overrun), 32'd0);
    chk("rst1_start", 32'(tx_start), 32'd0);
    repeat (2) @(negedge hclk);
    rst = 1'b1;
    send_byte(8'h10);
    repeat (2) @(negedge hclk);
    chk("req_start", 32'(tx_start), 32'd1);
    chk("req_txd", {24'h0, tx_data}, 32'h3F);
    rst = 1'b0;
    #1;
    chk("rst2_start", 32'(tx_start), 32'd0);
    chk("rst2_txd", {24'h0, tx_data}, 32'h0);
    chk("rst2_wa", {24'h0, wr_addr}, 32'h0);
    repeat (2) @(negedge hclk);
    rst = 1'b1;
    model_en = 1'b1;
    repeat (2) @(negedge hclk);

    sc0 = st_cnt;
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_byte(8'h03);
    send_byte(8'h5C);
    wait_idle();
    chk("post_reg3", {24'h0, regs[31:24]}, 32'h5C);
    chk("post_wa", {24'h0, last_wa}, 32'h3);
    chk("post_strobe", 32'(st_cnt - sc0), 32'd1);
    chk("post_regs", regs, 32'h5C00_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
